// File: rtl/button_gesture_decoder_if.sv
// Button event/gesture bundle between the debouncer side and the gesture decoder.
// The master drives debounced button events; the slave returns the gesture pulses.
interface button_gesture_decoder_if;
    logic pb_state;
    logic pb_down;
    logic pb_up;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_tick;
    logic held;
    logic busy;

    modport master (
        output pb_state, pb_down, pb_up,
        input  short_press, long_press, double_click, repeat_tick, held, busy
    );

    modport slave (
        input  pb_state, pb_down, pb_up,
        output short_press, long_press, double_click, repeat_tick, held, busy
    );
endinterface

// File: rtl/button_gesture_decoder.sv
// Turns debounced button events into short/long/double-click gesture pulses.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat tick generator for long holds.
module button_gesture_decoder #(
    parameter int              CNT_W         = 24,
    parameter logic [CNT_W-1:0] LONG_CYCLES   = CNT_W'(5_000_000),
    parameter logic [CNT_W-1:0] DCLICK_CYCLES = CNT_W'(2_500_000),
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = CNT_W'(1_000_000)
) (
    input logic                     clk,
    input logic                     rst_n,
    button_gesture_decoder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, WAIT_REL, LONG} state_e;

    localparam logic [CNT_W-1:0] LONG_TC = LONG_CYCLES - CNT_W'(1);
    localparam logic [CNT_W-1:0] DCL_TC  = DCLICK_CYCLES - CNT_W'(1);

    if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("button_gesture_decoder: cycle parameter out of range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             tick_q, tick_d;
    logic             held_q, held_d;
    logic             busy_q, busy_d;

    // A simultaneous up/down is treated as a release only.
    logic dn, gone;
    assign dn   = bus.pb_down & ~bus.pb_up;
    assign gone = bus.pb_up | ~bus.pb_state;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        tick_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dn) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                if (bus.pb_up) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (!bus.pb_state) begin
                    state_d = IDLE;
                end else if (cnt_q == LONG_TC) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT2: begin
                // Window expiry outranks a press landing on the very same edge.
                if (cnt_q == DCL_TC) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else if (dn) begin
                    dbl_d   = 1'b1;
                    state_d = WAIT_REL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                if (gone) state_d = IDLE;
            end
            LONG: begin
                if (gone) begin
                    state_d = IDLE;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (cnt_q == REPEAT_CYCLES - CNT_W'(1)) begin
                    tick_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        held_d = (state_d == LONG);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            tick_q  <= 1'b0;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            tick_q  <= tick_d;
            held_q  <= held_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_click = dbl_q;
    assign bus.repeat_tick  = tick_q;
    assign bus.held         = held_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder: directed gesture scenarios plus a random button
// stream, all compared edge by edge against a timestamp-based gesture model.
module tb_button_gesture_decoder;
    localparam int LONGC = 8;
    localparam int DCL   = 4;
    localparam int REP   = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_gesture_decoder_if bif();

    button_gesture_decoder #(
        .CNT_W(24), .LONG_CYCLES(24'd8), .DCLICK_CYCLES(24'd4), .REPEAT_CYCLES(24'd3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif.slave)
    );

    int n_chk = 0, n_fail = 0;
    int ecnt;
    // model: 0 idle, 1 pressed, 2 waiting for 2nd press, 3 waiting 2nd release, 4 long hold
    int m_mode, m_t0;
    int first_e[4], pulses[4], last_held, last_busy;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     tag, act, act, exp, exp, ecnt);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bif.short_press, bif.long_press, bif.double_click,
                bif.repeat_tick, bif.held, bif.busy};
    endfunction

    // Gesture rules expressed on edge timestamps: t0 is the press, release or last tick.
    task automatic model_step(input int t, input bit st, input bit dn_raw, input bit up,
                              output logic [5:0] ex);
        bit dn, gone;
        dn   = dn_raw & ~up;
        gone = up | ~st;
        ex   = '0;
        case (m_mode)
            0: if (dn) begin m_mode = 1; m_t0 = t; end
            1: if (up) begin m_mode = 2; m_t0 = t; end
               else if (!st) m_mode = 0;
               else if (t - m_t0 == LONGC) begin ex[4] = 1'b1; m_mode = 4; m_t0 = t; end
            2: if (t - m_t0 == DCL) begin ex[5] = 1'b1; m_mode = 0; end
               else if (dn) begin ex[3] = 1'b1; m_mode = 3; end
            3: if (gone) m_mode = 0;
            4: if (gone) m_mode = 0;
               else if (AR && t - m_t0 == REP) begin ex[2] = 1'b1; m_t0 = t; end
            default: m_mode = 0;
        endcase
        ex[1] = (m_mode == 4);
        ex[0] = (m_mode != 0);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin first_e[i] = 0; pulses[i] = 0; end
        last_held = 0;
        last_busy = 0;
    endtask

    task automatic step(input bit st, input bit dn, input bit up);
        logic [5:0] ex, ob;
        bif.pb_state = st;
        bif.pb_down  = dn;
        bif.pb_up    = up;
        @(posedge clk);
        ecnt++;
        model_step(ecnt, st, dn, up, ex);
        #1;
        ob = outs();
        chk("outs", 32'(ob), 32'(ex));
        for (int i = 0; i < 4; i++)
            if (ob[5-i]) begin
                pulses[i]++;
                if (first_e[i] == 0) first_e[i] = ecnt;
            end
        if (ob[1]) last_held = ecnt;
        if (ob[0]) last_busy = ecnt;
    endtask

    task automatic do_reset();
        bif.pb_state = 1'b0;
        bif.pb_down  = 1'b0;
        bif.pb_up    = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        ecnt   = 0;
        m_mode = 0;
        m_t0   = 0;
        clear_stats();
    endtask

    // Up to two presses; a press/release edge of 0 means "none".
    task automatic run(input int p1, input int r1, input int p2, input int r2, input int n);
        bit st, dn, up;
        do_reset();
        for (int e = 1; e <= n; e++) begin
            st = (e >= p1 && e < r1) || (p2 != 0 && e >= p2 && e < r2);
            dn = (e == p1) || (p2 != 0 && e == p2);
            up = (e == r1) || (p2 != 0 && e == r2);
            step(st, dn, up);
        end
    endtask

    initial begin
        int lvl, dur;
        bit lost;
        ecnt = 0;
        m_mode = 0;
        m_t0 = 0;
        bif.pb_state = 1'b0;
        bif.pb_down  = 1'b0;
        bif.pb_up    = 1'b0;

        // Single short press.
        run(10, 13, 0, 0, 30);
        chk("s1_short_edge", 32'(first_e[0]), 32'd17);
        chk("s1_short_cnt", 32'(pulses[0]), 32'd1);
        chk("s1_other_cnt", 32'(pulses[1] + pulses[2] + pulses[3]), 32'd0);
        chk("s1_busy_last", 32'(last_busy), 32'd16);

        // Long hold, released at edge 31.
        run(10, 31, 0, 0, 40);
        chk("s2_long_edge", 32'(first_e[1]), 32'd18);
        chk("s2_short_cnt", 32'(pulses[0]), 32'd0);
        chk("s2_held_last", 32'(last_held), 32'd30);
        chk("s2_tick_cnt", 32'(pulses[3]), AR ? 32'd4 : 32'd0);
        chk("s2_tick_first", 32'(first_e[3]), AR ? 32'd21 : 32'd0);

        // Double click.
        run(10, 12, 14, 20, 30);
        chk("s3_dbl_edge", 32'(first_e[2]), 32'd14);
        chk("s3_short_long_cnt", 32'(pulses[0] + pulses[1]), 32'd0);

        // Second press lands exactly at the window end: too late.
        run(10, 12, 16, 20, 30);
        chk("s4_short_edge", 32'(first_e[0]), 32'd16);
        chk("s4_dbl_cnt", 32'(pulses[2]), 32'd0);
        chk("s4_busy_last", 32'(last_busy), 32'd15);

        // Asynchronous reset in the middle of a press.
        do_reset();
        for (int e = 1; e <= 14; e++) step(e >= 10, e == 10, 1'b0);
        chk("s5_busy_before", 32'(bif.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_async_clear", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_mode = 0;
        clear_stats();
        for (int e = 0; e < 20; e++) step(1'b1, 1'b0, 1'b0);
        chk("s5_no_events", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3] + last_busy), 32'd0);

        // Random button stream with occasional lost releases and up/down collisions.
        do_reset();
        lvl = 0;
        dur = 3;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                step(lvl != 0, 1'b1, 1'b1);
            end else if (dur == 0) begin
                if (lvl == 0) begin
                    lvl = 1;
                    step(1'b1, 1'b1, 1'b0);
                end else begin
                    lvl  = 0;
                    lost = ($urandom_range(0, 19) == 0);
                    step(1'b0, 1'b0, !lost);
                end
                dur = $urandom_range(1, 14);
            end else begin
                step(lvl != 0, 1'b0, 1'b0);
                dur--;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
